// File: rtl/keypad_pkg.sv
// Shared types, constants and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  localparam int          NUM_ROWS   = 4;
  localparam int          NUM_COLS   = 4;
  localparam int          KEY_CODE_W = 4;
  localparam logic [3:0]  COL_RESET  = 4'b1110;

  // Walk the single low bit one column to the left, wrapping 0111 -> 1110.
  function automatic logic [NUM_COLS-1:0] rotate_col(input logic [NUM_COLS-1:0] col);
    return {col[NUM_COLS-2:0], col[NUM_COLS-1]};
  endfunction

  // Index of the lowest-numbered row that is pulled low; row 0 wins ties.
  function automatic logic [1:0] first_low_row(input logic [NUM_ROWS-1:0] rs);
    logic [1:0] idx;
    if (!rs[0]) begin
      idx = 2'd0;
    end else if (!rs[1]) begin
      idx = 2'd1;
    end else if (!rs[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pin bundle plus the key-event outputs seen by downstream logic.
interface keypad_if
  import keypad_pkg::*;
  ();
  logic [NUM_ROWS-1:0]   ROW;
  logic [NUM_COLS-1:0]   COL;
  logic [KEY_CODE_W-1:0] KEY_CODE;
  logic                  KEY_VALID;
  logic                  KEY_HELD;

  modport master (
    input  ROW,
    output COL,
    output KEY_CODE,
    output KEY_VALID,
    output KEY_HELD
  );

  modport slave (
    output ROW,
    input  COL,
    input  KEY_CODE,
    input  KEY_VALID,
    input  KEY_HELD
  );
endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle strobe every 2^SCAN_DIV_W cycles.
module tick_gen #(
  parameter int SCAN_DIV_W = 16
) (
  input  logic CLK,
  input  logic RESET,
  output logic TICK
);

  logic [SCAN_DIV_W-1:0] presc_q;
  logic [SCAN_DIV_W-1:0] presc_d;

  // Next prescaler value: count up and wrap naturally.
  always_comb begin
    presc_d = presc_q + {{(SCAN_DIV_W-1){1'b0}}, 1'b1};
  end

  // Prescaler register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign TICK = &presc_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column drive, row synchroniser, row priority
// select and a scan/debounce/held FSM emitting one strobe per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W     = 16,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic     CLK,
  input  logic     RESET,
  keypad_if.master kp
);

  localparam logic [3:0] DB_LIM = 4'(DEBOUNCE_TICKS);

  logic                  tick_s;
  logic [NUM_ROWS-1:0]   rs_meta_q;
  logic [NUM_ROWS-1:0]   rs_q;
  logic                  any_low_s;
  logic [1:0]            sel_row_s;
  logic [3:0]            cnt_inc_s;

  state_e                state_q,     state_d;
  logic [NUM_COLS-1:0]   col_q,       col_d;
  logic [1:0]            col_idx_q,   col_idx_d;
  logic [1:0]            row_idx_q,   row_idx_d;
  logic [3:0]            cnt_q,       cnt_d;
  logic [KEY_CODE_W-1:0] key_code_q,  key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_held_q,  key_held_d;

  tick_gen #(.SCAN_DIV_W(SCAN_DIV_W)) u_tick_gen (
    .CLK   (CLK),
    .RESET (RESET),
    .TICK  (tick_s)
  );

  // Two-flop synchroniser for the asynchronous row inputs (idle = all high).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rs_meta_q <= 4'b1111;
      rs_q      <= 4'b1111;
    end else begin
      rs_meta_q <= kp.ROW;
      rs_q      <= rs_meta_q;
    end
  end

  assign any_low_s = ~(&rs_q);
  assign sel_row_s = first_low_row(rs_q);
  assign cnt_inc_s = cnt_q + 4'd1;

  // Next-state and output logic; everything advances only on scan ticks,
  // except the valid strobe which always drops after one cycle.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (tick_s) begin
      case (state_q)
        SCAN: begin
          if (!any_low_s) begin
            col_d     = rotate_col(col_q);
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = sel_row_s;
            cnt_d     = 4'd1;
            state_d   = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (any_low_s && (sel_row_s == row_idx_q)) begin
            if (cnt_inc_s == DB_LIM) begin
              key_code_d  = {row_idx_q, col_idx_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = 4'd0;
              state_d     = HELD;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end else begin
            cnt_d     = 4'd0;
            col_d     = rotate_col(col_q);
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end
        end
        HELD: begin
          // Only the latched row matters here; other keys are ignored.
          if (rs_q[row_idx_q]) begin
            if (cnt_inc_s == DB_LIM) begin
              key_held_d = 1'b0;
              cnt_d      = 4'd0;
              col_d      = rotate_col(col_q);
              col_idx_d  = col_idx_q + 2'd1;
              state_d    = SCAN;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: begin
          state_d    = SCAN;
          cnt_d      = 4'd0;
          col_d      = COL_RESET;
          col_idx_d  = 2'd0;
          key_held_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= SCAN;
      col_q       <= COL_RESET;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      cnt_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.COL       = col_q;
  assign kp.KEY_CODE  = key_code_q;
  assign kp.KEY_VALID = key_valid_q;
  assign kp.KEY_HELD  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 switch matrix.
// Tick index t corresponds to the (16*t)-th rising edge after reset release;
// samples are taken 1 time unit after that edge.
module tb_keypad_scanner;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] keys = 16'h0000;
  logic [3:0]  row_s;
  int          n_checks = 0;
  int          n_pass = 0;
  int          vcount = 0;
  int          pos = 0;
  int          vbase;

  keypad_if kp ();

  keypad_scanner #(
    .SCAN_DIV_W     (4),
    .DEBOUNCE_TICKS (3)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .kp    (kp)
  );

  always #5 CLK = ~CLK;

  // Switch matrix: a closed key pulls its row low when its column is driven low.
  always_comb begin
    row_s = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !kp.COL[c]) row_s[r] = 1'b0;
      end
    end
  end
  assign kp.ROW = row_s;

  // Count clock cycles on which the valid strobe is high.
  always @(negedge CLK) begin
    if (kp.KEY_VALID === 1'b1) vcount = vcount + 1;
  end

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic to_tick(input int t);
    repeat ((t - pos) * 16) @(posedge CLK);
    #1;
    pos = t;
  endtask

  task automatic set_key(input int r, input int c, input logic v);
    keys[r*4+c] = v;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_col"},   8'(kp.COL),       8'h0e);
    check_val({tag, "_code"},  8'(kp.KEY_CODE),  8'h00);
    check_val({tag, "_valid"}, 8'(kp.KEY_VALID), 8'h00);
    check_val({tag, "_held"},  8'(kp.KEY_HELD),  8'h00);
  endtask

  // Assert reset asynchronously mid-cycle, check, release on a falling edge.
  task automatic do_reset(input string tag);
    RESET = 1'b0;
    #1;
    check_reset_vals(tag);
    @(negedge CLK);
    RESET = 1'b1;
    pos = 0;
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(posedge CLK);
    #1;
    check_reset_vals("por");
    @(negedge CLK);
    RESET = 1'b1;
    pos = 0;

    // Idle scan rotation
    to_tick(1); check_val("scan1", 8'(kp.COL), 8'h0d);
    to_tick(2); check_val("scan2", 8'(kp.COL), 8'h0b);
    to_tick(3); check_val("scan3", 8'(kp.COL), 8'h07);
    to_tick(4); check_val("scan4", 8'(kp.COL), 8'h0e);

    // Row2/col1 held for 20 ticks
    set_key(2, 1, 1'b1);
    to_tick(8);
    check_val("p1_valid", 8'(kp.KEY_VALID), 8'h01);
    check_val("p1_code",  8'(kp.KEY_CODE),  8'h09);
    check_val("p1_held",  8'(kp.KEY_HELD),  8'h01);
    to_tick(24);
    check_val("p1_hold_long", 8'(kp.KEY_HELD), 8'h01);
    check_val("p1_col_frozen", 8'(kp.COL), 8'h0d);
    check_val("p1_one_pulse", 8'(vcount), 8'd1);
    set_key(2, 1, 1'b0);
    to_tick(26); check_val("p1_rel2", 8'(kp.KEY_HELD), 8'h01);
    to_tick(27);
    check_val("p1_rel3", 8'(kp.KEY_HELD), 8'h00);
    check_val("p1_col_resume", 8'(kp.COL), 8'h0b);
    to_tick(28); check_val("p1_scan_next", 8'(kp.COL), 8'h07);

    // Press bounce: two low samples then release
    to_tick(30);
    set_key(2, 1, 1'b1);
    to_tick(32);
    set_key(2, 1, 1'b0);
    to_tick(33);
    check_val("bnc_col",   8'(kp.COL),      8'h0b);
    check_val("bnc_code",  8'(kp.KEY_CODE), 8'h09);
    check_val("bnc_held",  8'(kp.KEY_HELD), 8'h00);
    check_val("bnc_nopulse", 8'(vcount),    8'd1);

    // Rows 1 and 3 on col0: row 1 wins
    set_key(1, 0, 1'b1);
    set_key(3, 0, 1'b1);
    to_tick(38);
    check_val("prio_valid", 8'(kp.KEY_VALID), 8'h01);
    check_val("prio_code",  8'(kp.KEY_CODE),  8'h04);
    check_val("prio_held",  8'(kp.KEY_HELD),  8'h01);
    keys = 16'h0000;
    to_tick(41);
    check_val("prio_rel",   8'(kp.KEY_HELD), 8'h00);
    check_val("prio_col",   8'(kp.COL),      8'h0d);
    check_val("prio_pulses", 8'(vcount),     8'd2);

    // Release bounce in HELD, plus another key pressed while held
    set_key(2, 1, 1'b1);
    to_tick(44);
    check_val("rb_valid", 8'(kp.KEY_VALID), 8'h01);
    check_val("rb_code",  8'(kp.KEY_CODE),  8'h09);
    set_key(2, 1, 1'b0);
    set_key(0, 1, 1'b1);
    to_tick(46);
    set_key(2, 1, 1'b1);
    set_key(0, 1, 1'b0);
    to_tick(47);
    set_key(2, 1, 1'b0);
    to_tick(49);
    check_val("rb_held_mid", 8'(kp.KEY_HELD), 8'h01);
    check_val("rb_code_kept", 8'(kp.KEY_CODE), 8'h09);
    to_tick(50);
    check_val("rb_held_end", 8'(kp.KEY_HELD), 8'h00);
    check_val("rb_col",      8'(kp.COL),      8'h0b);
    check_val("rb_pulses",   8'(vcount),      8'd3);

    // Reset mid-DEBOUNCE, then re-detect from col0
    set_key(2, 1, 1'b1);
    to_tick(54);
    check_val("rd_pre_col", 8'(kp.COL), 8'h0d);
    vbase = vcount;
    do_reset("rst_deb");
    to_tick(4);
    check_val("rd_valid", 8'(kp.KEY_VALID), 8'h01);
    check_val("rd_code",  8'(kp.KEY_CODE),  8'h09);
    to_tick(5);
    check_val("rh_pre_held", 8'(kp.KEY_HELD), 8'h01);

    // Reset mid-HELD, then re-detect again
    do_reset("rst_held");
    to_tick(4);
    check_val("rh_valid", 8'(kp.KEY_VALID), 8'h01);
    check_val("rh_code",  8'(kp.KEY_CODE),  8'h09);
    to_tick(5);
    check_val("rh_pulses", 8'(vcount - vbase), 8'd2);
    set_key(2, 1, 1'b0);
    to_tick(9);
    check_val("rh_rel_held", 8'(kp.KEY_HELD), 8'h00);
    check_val("rh_rel_col",  8'(kp.COL),      8'h07);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad and reports one debounced key code per press. It is the input-side counterpart of the board's LED/DIP user-I/O logic. COL drives one column low at a time on a divided scan tick. ROW is synchronised and sampled, and a confirmed press yields a one-cycle KEY_VALID strobe with a 4-bit code. The block sits between the board keypad pins and any downstream consumer, such as the LED pattern controller.

## Interface
- SCAN_DIV_W, 16: prescaler width; scan tick every 2^SCAN_DIV_W CLK cycles.
- DEBOUNCE_TICKS, 4: consecutive identical tick samples needed to accept a press or a release (range 2..15).
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset; clock CLK.
- ROW  in  4  keypad rows, pulled up, low = key closed on driven column; asynchronous to CLK.
- COL  out  4  column drive, exactly one bit low at all times.
- KEY_CODE  out  4  {row_idx[1:0], col_idx[1:0]} of last accepted key; holds until next accept.
- KEY_VALID  out  1  one-CLK strobe on press acceptance.
- KEY_HELD  out  1  high while accepted key remains pressed, including release debounce.

## Operation
- Reset values: COL=4'b1110, KEY_CODE=0, KEY_VALID=0, KEY_HELD=0, state SCAN, prescaler=0, debounce count=0, synchroniser flops=4'b1111.
- ROW passes through a 2-flop synchroniser; all decisions use the synchronised value rs.
- Prescaler free-runs and wraps; tick is a 1-cycle strobe when prescaler == all-ones.
- Row select: if multiple rs bits are low, the lowest index wins (row 0 highest priority).
- FSM, evaluated only on tick cycles except KEY_VALID clear:
  - SCAN:
    - rs == 4'b1111: rotate COL left by one (1110->1101->1011->0111->1110), col_idx increments mod 4.
    - Otherwise: latch row_idx/col_idx, count=1, go DEBOUNCE; COL frozen.
  - DEBOUNCE:
    - Selected row still low, same row_idx: count++.
    - Count reaches DEBOUNCE_TICKS: load KEY_CODE, pulse KEY_VALID, set KEY_HELD, count=0, go HELD.
    - Any mismatch (row released or different row wins): count=0, rotate COL, go SCAN.
  - HELD:
    - Latched row high: count++; else count=0.
    - Count reaches DEBOUNCE_TICKS: clear KEY_HELD, count=0, rotate COL, go SCAN.
- No auto-repeat; a held key produces exactly one KEY_VALID.
- Other keys pressed while in HELD are ignored.
- Reset asserted in any state returns all state and outputs to reset values immediately; no KEY_VALID is emitted on reset exit.

## Timing
- ROW-to-rs latency: 2 CLK cycles.
- COL changes in the CLK cycle after a tick. Rows therefore settle a full tick period before the next sample.
- KEY_VALID is high exactly 1 CLK cycle: the cycle after the tick on which the DEBOUNCE_TICKS-th matching sample occurs. KEY_CODE and KEY_HELD update in that same cycle.
- Press-to-KEY_VALID: up to 4 ticks to reach the column, plus (DEBOUNCE_TICKS-1) ticks, plus 1 CLK, plus 2 CLK synchroniser latency.
- KEY_HELD falls in the cycle after the tick completing release debounce.

## Structure
- Package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, HELD}
  - COL_RESET=4'b1110
  - KEY_CODE_W=4
  - row/column counts (4)
- Sub-module tick_gen (parameter SCAN_DIV_W; ports CLK, RESET, TICK): prescaler and strobe. Reused later for LED pacing.
- Synchroniser, priority encoder and FSM are written inline in keypad_scanner.

## Test plan
Bench uses SCAN_DIV_W=4 (tick every 16 CLK) and DEBOUNCE_TICKS=3.
- Reset -> COL=1110, KEY_CODE=0, KEY_VALID=0, KEY_HELD=0. With no key pressed, COL cycles 1110,1101,1011,0111,1110, one step per 16 CLK.
- Key row2/col1 held 20 ticks -> exactly one KEY_VALID pulse of 1 CLK with KEY_CODE=4'b1001. KEY_HELD=1 until 3 ticks after release, then scanning resumes.
- Row2/col1 bounce, low for 2 ticks then high -> no KEY_VALID, KEY_CODE unchanged, scan resumes from col2.
- Rows 1 and 3 both low on col0 -> KEY_CODE=4'b0100.
- Release bounce in HELD (high 2 ticks, low 1 tick, high 3 ticks) -> KEY_HELD stays high until the final 3-tick release, with no second KEY_VALID.
- RESET asserted mid-DEBOUNCE and mid-HELD -> outputs return to reset values asynchronously. After release, the held key is re-detected from col0 and yields one fresh KEY_VALID.
